// File: rtl/tictactoe_game_ctrl_if.sv
// Move/checker/status bundle between the game controller and its surroundings.
// The master side presents moves and the checker's verdict; the slave side is the controller.
interface tictactoe_game_ctrl_if;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       chk_error;
    logic       chk_full;
    logic       chk_win_x;
    logic       chk_win_o;
    logic [8:0] x;
    logic [8:0] o;
    logic       turn;
    logic       move_ready;
    logic       move_ack;
    logic       move_reject;
    logic       game_over;
    logic [1:0] result;
    logic       timed_out;
    logic       err_flag;
    logic [3:0] move_cnt;

    modport master (
        output new_game, move_valid, move_pos, chk_error, chk_full, chk_win_x, chk_win_o,
        input  x, o, turn, move_ready, move_ack, move_reject, game_over, result,
               timed_out, err_flag, move_cnt
    );

    modport slave (
        input  new_game, move_valid, move_pos, chk_error, chk_full, chk_win_x, chk_win_o,
        output x, o, turn, move_ready, move_ack, move_reject, game_over, result,
               timed_out, err_flag, move_cnt
    );
endinterface

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game controller: owns the X/O boards, alternates turns, enforces an
// optional per-move timeout and turns the external checker's verdict into DONE/ERR.
module tictactoe_game_ctrl #(
    parameter bit FIRST_O        = 1'b0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    tictactoe_game_ctrl_if.slave bus
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {PLAY, CHECK, DONE, ERR} state_t;

    state_t          state, state_d;
    logic [8:0]      x_q, x_d, o_q, o_d;
    logic            turn_q, turn_d;
    logic            ack_q, ack_d, rej_q, rej_d;
    logic [1:0]      result_q, result_d;
    logic            tmo_q, tmo_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     occ;
    logic            legal;

    // Padded to 16 so any 4-bit position can index it; cells 9..15 read as free but are rejected by range.
    assign occ   = {7'b0, x_q | o_q};
    assign legal = bus.move_valid && (bus.move_pos <= 4'd8) && !occ[bus.move_pos];

    always_comb begin
        state_d  = state;
        x_d      = x_q;
        o_d      = o_q;
        turn_d   = turn_q;
        ack_d    = 1'b0;
        rej_d    = 1'b0;
        result_d = result_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        if (bus.new_game) begin
            state_d  = PLAY;
            x_d      = '0;
            o_d      = '0;
            turn_d   = FIRST_O;
            result_d = 2'b00;
            tmo_d    = 1'b0;
            cnt_d    = '0;
            timer_d  = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (legal) begin
                        if (turn_q) o_d = o_q | (9'b1 << bus.move_pos);
                        else        x_d = x_q | (9'b1 << bus.move_pos);
                        if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
                        ack_d   = 1'b1;
                        state_d = CHECK;
                    end else begin
                        rej_d = bus.move_valid;
                        // A legal move on the last allowed cycle takes precedence over the forfeit.
                        if (TIMEOUT_CYCLES > 0) begin
                            if (timer_q == T_LAST) begin
                                state_d  = DONE;
                                result_d = turn_q ? 2'b01 : 2'b10;
                                tmo_d    = 1'b1;
                            end else begin
                                timer_d = timer_q + 1'b1;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (bus.chk_error) begin
                        state_d = ERR;
                    end else if (bus.chk_win_x) begin
                        state_d  = DONE;
                        result_d = 2'b01;
                    end else if (bus.chk_win_o) begin
                        state_d  = DONE;
                        result_d = 2'b10;
                    end else if (bus.chk_full) begin
                        state_d  = DONE;
                        result_d = 2'b11;
                    end else begin
                        state_d = PLAY;
                        turn_d  = ~turn_q;
                        timer_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PLAY;
            x_q      <= '0;
            o_q      <= '0;
            turn_q   <= FIRST_O;
            ack_q    <= 1'b0;
            rej_q    <= 1'b0;
            result_q <= 2'b00;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
            timer_q  <= '0;
        end else begin
            state    <= state_d;
            x_q      <= x_d;
            o_q      <= o_d;
            turn_q   <= turn_d;
            ack_q    <= ack_d;
            rej_q    <= rej_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.o           = o_q;
    assign bus.turn        = turn_q;
    assign bus.move_ready  = (state == PLAY);
    assign bus.move_ack    = ack_q;
    assign bus.move_reject = rej_q;
    assign bus.game_over   = (state == DONE);
    assign bus.result      = result_q;
    assign bus.timed_out   = tmo_q;
    assign bus.err_flag    = (state == ERR);
    assign bus.move_cnt    = cnt_q;
endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Bench for tictactoe_game_ctrl: behavioural checker model, move scoreboard on the
// untimed instance, direct checks on a TIMEOUT_CYCLES=4 instance.
module tb_tictactoe_game_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tictactoe_game_ctrl_if bus();
    tictactoe_game_ctrl_if tbus();

    localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                          9'h092, 9'h124, 9'h111, 9'h054};

    function automatic logic has_line(input logic [8:0] b);
        has_line = 1'b0;
        for (int i = 0; i < 8; i++) if ((b & LINES[i]) == LINES[i]) has_line = 1'b1;
    endfunction

    logic force_err = 1'b0;
    assign bus.chk_error  = force_err | (|(bus.x & bus.o));
    assign bus.chk_full   = &(bus.x | bus.o);
    assign bus.chk_win_x  = has_line(bus.x);
    assign bus.chk_win_o  = has_line(bus.o);
    assign tbus.chk_error = |(tbus.x & tbus.o);
    assign tbus.chk_full  = &(tbus.x | tbus.o);
    assign tbus.chk_win_x = has_line(tbus.x);
    assign tbus.chk_win_o = has_line(tbus.o);

    tictactoe_game_ctrl #(.FIRST_O(1'b0), .TIMEOUT_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    tictactoe_game_ctrl #(.FIRST_O(1'b0), .TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .bus(tbus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       ack;
        logic [8:0] x;
        logic [8:0] o;
        logic [3:0] cnt;
    } exp_t;

    exp_t sbq[$];

    logic [8:0] mx, mo;
    logic       mturn;
    logic [3:0] mcnt;

    task automatic model_reset();
        mx = '0; mo = '0; mturn = 1'b0; mcnt = '0;
    endtask

    // Pulses are matched in order against the expected outcome of each presented move.
    always @(negedge clk) begin
        exp_t e;
        if (bus.move_ack || bus.move_reject) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_pulse", {bus.move_ack, bus.move_reject}, 2'b00);
            end else begin
                e = sbq.pop_front();
                check("sb_ack", bus.move_ack, e.ack);
                check("sb_rej", bus.move_reject, !e.ack);
                check("sb_x", bus.x, e.x);
                check("sb_o", bus.o, e.o);
                check("sb_cnt", bus.move_cnt, e.cnt);
            end
        end
    end

    task automatic do_move(input logic [3:0] pos);
        exp_t        e;
        logic [15:0] occ;
        logic        legal;
        occ   = {7'b0, mx | mo};
        legal = (pos <= 4'd8) && !occ[pos];
        if (legal) begin
            if (mturn) mo[pos] = 1'b1;
            else       mx[pos] = 1'b1;
            mcnt++;
        end
        e.ack = legal; e.x = mx; e.o = mo; e.cnt = mcnt;
        sbq.push_back(e);
        bus.move_valid = 1'b1;
        bus.move_pos   = pos;
        @(posedge clk);
        @(negedge clk);
        bus.move_valid = 1'b0;
        check("ack_latency", bus.move_ack, legal);
        @(posedge clk);
        @(negedge clk);
        if (legal && !force_err && !has_line(mx) && !has_line(mo) && !(&(mx | mo)))
            mturn = ~mturn;
        check("turn", bus.turn, mturn);
        check("move_cnt", bus.move_cnt, mcnt);
    endtask

    task automatic new_game_main();
        bus.new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.new_game = 1'b0;
        model_reset();
    endtask

    task automatic new_game_t();
        tbus.new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tbus.new_game = 1'b0;
    endtask

    initial begin
        exp_t e;
        bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_pos = '0;
        tbus.new_game = 1'b0; tbus.move_valid = 1'b0; tbus.move_pos = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_x", bus.x, 9'h000);
        check("rst_o", bus.o, 9'h000);
        check("rst_turn", bus.turn, 1'b0);
        check("rst_ready", bus.move_ready, 1'b1);
        check("rst_flags", {bus.move_ack, bus.move_reject, bus.game_over, bus.timed_out, bus.err_flag}, 5'b0);
        check("rst_result", bus.result, 2'b00);
        check("rst_cnt", bus.move_cnt, 4'd0);

        // X wins along the top row
        do_move(4'd0); do_move(4'd3); do_move(4'd1); do_move(4'd4); do_move(4'd2);
        check("win_result", bus.result, 2'b01);
        check("win_over", bus.game_over, 1'b1);
        check("win_ready", bus.move_ready, 1'b0);
        check("win_x", bus.x, 9'h007);
        check("win_o", bus.o, 9'h018);
        bus.move_valid = 1'b1; bus.move_pos = 4'd5;
        repeat (2) @(negedge clk);
        bus.move_valid = 1'b0;
        check("done_ignores_x", bus.x, 9'h007);
        check("done_ignores_o", bus.o, 9'h018);

        // Rejects: occupied cell and out-of-range positions
        new_game_main();
        check("ng_board", {bus.x, bus.o}, 18'h0);
        check("ng_over", bus.game_over, 1'b0);
        do_move(4'd0); do_move(4'd0); do_move(4'd9); do_move(4'd15);
        check("rej_x", bus.x, 9'h001);
        check("rej_o", bus.o, 9'h000);

        // Draw, then a tenth move is impossible
        new_game_main();
        do_move(4'd0); do_move(4'd1); do_move(4'd2); do_move(4'd4); do_move(4'd3);
        do_move(4'd5); do_move(4'd7); do_move(4'd6); do_move(4'd8);
        check("draw_result", bus.result, 2'b11);
        check("draw_cnt", bus.move_cnt, 4'd9);
        check("draw_over", bus.game_over, 1'b1);

        // Checker error during CHECK
        new_game_main();
        do_move(4'd0);
        force_err = 1'b1;
        do_move(4'd4);
        force_err = 1'b0;
        check("err_flag", bus.err_flag, 1'b1);
        check("err_over", bus.game_over, 1'b0);
        check("err_result", bus.result, 2'b00);

        // new_game wins over a simultaneous move
        bus.new_game = 1'b1; bus.move_valid = 1'b1; bus.move_pos = 4'd4;
        @(posedge clk);
        @(negedge clk);
        bus.new_game = 1'b0; bus.move_valid = 1'b0;
        model_reset();
        check("ngmv_board", {bus.x, bus.o}, 18'h0);
        check("ngmv_pulses", {bus.move_ack, bus.move_reject}, 2'b00);
        check("ngmv_err", bus.err_flag, 1'b0);
        check("ngmv_ready", bus.move_ready, 1'b1);

        // Asynchronous reset while in CHECK
        e.ack = 1'b1; e.x = 9'h010; e.o = 9'h000; e.cnt = 4'd1;
        sbq.push_back(e);
        bus.move_valid = 1'b1; bus.move_pos = 4'd4;
        @(posedge clk);
        @(negedge clk);
        bus.move_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_board", {bus.x, bus.o}, 18'h0);
        check("arst_ack", bus.move_ack, 1'b0);
        check("arst_cnt", bus.move_cnt, 4'd0);
        check("arst_ready", bus.move_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Timeout: four idle PLAY cycles forfeit to the opponent
        new_game_t();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tmo_not_yet", tbus.game_over, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("tmo_over", tbus.game_over, 1'b1);
        check("tmo_result", tbus.result, 2'b10);
        check("tmo_flag", tbus.timed_out, 1'b1);

        // A move on the last allowed cycle is accepted; then O forfeits to X
        new_game_t();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tbus.move_valid = 1'b1; tbus.move_pos = 4'd4;
        @(posedge clk);
        @(negedge clk);
        tbus.move_valid = 1'b0;
        check("tmo_last_ack", tbus.move_ack, 1'b1);
        check("tmo_last_over", tbus.game_over, 1'b0);
        check("tmo_last_x", tbus.x, 9'h010);
        @(posedge clk);
        @(negedge clk);
        check("tmo_turn", tbus.turn, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tmo2_not_yet", tbus.game_over, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("tmo2_result", tbus.result, 2'b01);
        check("tmo2_flag", tbus.timed_out, 1'b1);

        check("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
